ccm_aes_arb: RTL and testbench



---
 rtl/ccm_pkg.sv | 18 +
 rtl/ccm_aes_arb_if.sv | 33 +++
 rtl/ccm_arb_tag_fifo.sv | 47 ++++
 rtl/ccm_aes_arb.sv | 119 +++++++++++
 tb/tb_ccm_aes_arb.sv | 247 ++++++++++++++++++++++++
 5 files changed

// File: rtl/ccm_pkg.sv
// Shared types and constants for the CCM AES engine arbiter.
// Holds the default block width and the requester IDs (0 = CBC-MAC, 1 = CTR).
// Also holds a helper that maps a requester ID to its one-hot strobe.
package ccm_pkg;

  parameter int DEF_WIDTH_BLOCK = 128;

  typedef logic req_id_t;

  localparam req_id_t REQ_MAC = 1'b0;
  localparam req_id_t REQ_CTR = 1'b1;

  // Bit 0 strobes the MAC requester, bit 1 strobes the CTR requester.
  function automatic logic [1:0] id_to_onehot(input req_id_t id);
    return (id == REQ_CTR) ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/ccm_aes_arb_if.sv
// Bundle of request, engine and response signals around the shared AES engine.
// The slave modport is the arbiter's view; master is the surrounding logic.
// out_cnt and err_unexp ride along as status outputs of the arbiter.
interface ccm_aes_arb_if import ccm_pkg::*; #(
  parameter int WIDTH_BLOCK = DEF_WIDTH_BLOCK,
  parameter int MAX_OUT     = 4
);
  localparam int WIDTH_OUT = $clog2(MAX_OUT + 1);

  logic [1:0]             req_valid;
  logic [WIDTH_BLOCK-1:0] req_data_0;
  logic [WIDTH_BLOCK-1:0] req_data_1;
  logic [1:0]             req_ready;
  logic                   aes_in_en;
  logic [WIDTH_BLOCK-1:0] aes_in_data;
  logic                   aes_out_en;
  logic [WIDTH_BLOCK-1:0] aes_out_data;
  logic [1:0]             rsp_en;
  logic [WIDTH_BLOCK-1:0] rsp_data;
  logic [WIDTH_OUT-1:0]   out_cnt;
  logic                   err_unexp;

  modport slave (
    input  req_valid, req_data_0, req_data_1, aes_out_en, aes_out_data,
    output req_ready, aes_in_en, aes_in_data, rsp_en, rsp_data, out_cnt, err_unexp
  );

  modport master (
    output req_valid, req_data_0, req_data_1, aes_out_en, aes_out_data,
    input  req_ready, aes_in_en, aes_in_data, rsp_en, rsp_data, out_cnt, err_unexp
  );

endinterface

// File: rtl/ccm_arb_tag_fifo.sv
// Purpose: 1-bit owner-tag FIFO recording which requester owns each in-flight block.
// Latency: a pushed tag is visible at head_id the cycle after the push edge.
// Backpressure: push is ignored when full and pop when empty; the caller keeps both legal.
module ccm_arb_tag_fifo import ccm_pkg::*; #(
  parameter int DEPTH = 4
) (
  input  logic    clk,
  input  logic    rst,
  input  logic    push,
  input  req_id_t push_id,
  input  logic    pop,
  output req_id_t head_id,
  output logic    empty,
  output logic    full
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  req_id_t       mem [DEPTH];
  logic [AW:0]   wr_ptr;
  logic [AW:0]   rd_ptr;
  logic          do_push;
  logic          do_pop;

  // Extra pointer MSB distinguishes full from empty when the indices match.
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head_id = mem[rd_ptr[AW-1:0]];

  // Pointer advance; reset empties the FIFO and discards any stored tags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + (AW + 1)'(1);
      if (do_pop)  rd_ptr <= rd_ptr + (AW + 1)'(1);
    end
  end

  // Tag storage; contents are meaningless while empty so no reset is needed.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= push_id;
  end

endmodule

// File: rtl/ccm_aes_arb.sv
// Purpose: shares one pipelined AES engine between the CCM MAC and CTR paths, routing results back by owner.
// Latency: accept edge -> aes_in_en next cycle; aes_out_en edge -> rsp_en next cycle.
// Backpressure: req_ready drops while MAX_OUT blocks are in flight; responses have no backpressure.
// Build option CCM_ARB_FIXED_PRI_EN: MAC always wins ties (no round-robin pointer).
module ccm_aes_arb import ccm_pkg::*; #(
  parameter int WIDTH_BLOCK = DEF_WIDTH_BLOCK,
  parameter int MAX_OUT     = 4
) (
  input logic          clk,
  input logic          reset,
  ccm_aes_arb_if.slave bus
);
  localparam int                   WIDTH_OUT = $clog2(MAX_OUT + 1);
  localparam logic [WIDTH_OUT-1:0] CNT_MAX   = WIDTH_OUT'(MAX_OUT);

  logic [1:0]             grant;
  req_id_t                win_id;
  logic                   room;
  logic                   accept;
  logic                   pop;
  logic                   spurious;
  req_id_t                head_id;
  logic                   fifo_empty;
  logic                   fifo_full;
  logic [WIDTH_OUT-1:0]   cnt;
  logic                   in_en_q;
  logic [WIDTH_BLOCK-1:0] in_data_q;
  logic [1:0]             rsp_en_q;
  logic [WIDTH_BLOCK-1:0] rsp_data_q;
  logic                   err_q;

`ifndef CCM_ARB_FIXED_PRI_EN
  req_id_t                last_win;
`endif

  // Pick the winner: a lone requester wins; on a tie the build option decides.
  always_comb begin
    win_id = REQ_MAC;
    if (bus.req_valid == 2'b11) begin
`ifdef CCM_ARB_FIXED_PRI_EN
      win_id = REQ_MAC;
`else
      win_id = ~last_win;
`endif
    end else if (bus.req_valid[1]) begin
      win_id = REQ_CTR;
    end
    grant = (bus.req_valid != 2'b00) ? id_to_onehot(win_id) : 2'b00;
  end

  // Registered count gates acceptance, so a same-cycle pop never frees a slot early.
  assign room          = (cnt < CNT_MAX) && !fifo_full;
  assign bus.req_ready = grant & {2{room}};
  assign accept        = |(bus.req_valid & bus.req_ready);
  assign pop           = bus.aes_out_en && !fifo_empty;
  assign spurious      = bus.aes_out_en && (cnt == '0);

  ccm_arb_tag_fifo #(.DEPTH(MAX_OUT)) u_tag_fifo (
    .clk     (clk),
    .rst     (reset),
    .push    (accept),
    .push_id (win_id),
    .pop     (pop),
    .head_id (head_id),
    .empty   (fifo_empty),
    .full    (fifo_full)
  );

`ifndef CCM_ARB_FIXED_PRI_EN
  // Round-robin pointer moves only when a block is actually accepted.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)       last_win <= REQ_CTR;
    else if (accept) last_win <= win_id;
  end
`endif

  // In-flight count: push and pop in the same cycle cancel out.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                cnt <= '0;
    else if (accept && !pop)  cnt <= cnt + WIDTH_OUT'(1);
    else if (!accept && pop)  cnt <= cnt - WIDTH_OUT'(1);
  end

  // Engine issue register: strobe follows acceptance, data is captured only on accept.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      in_en_q   <= 1'b0;
      in_data_q <= '0;
    end else begin
      in_en_q <= accept;
      if (accept) in_data_q <= (win_id == REQ_CTR) ? bus.req_data_1 : bus.req_data_0;
    end
  end

  // Response register: the popped owner tag steers the strobe; data is shared.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rsp_en_q   <= 2'b00;
      rsp_data_q <= '0;
    end else begin
      rsp_en_q <= pop ? id_to_onehot(head_id) : 2'b00;
      if (pop) rsp_data_q <= bus.aes_out_data;
    end
  end

  // Sticky flag for a result that arrives with nothing in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)         err_q <= 1'b0;
    else if (spurious) err_q <= 1'b1;
  end

  assign bus.aes_in_en   = in_en_q;
  assign bus.aes_in_data = in_data_q;
  assign bus.rsp_en      = rsp_en_q;
  assign bus.rsp_data    = rsp_data_q;
  assign bus.out_cnt     = cnt;
  assign bus.err_unexp   = err_q;

endmodule

// File: tb/tb_ccm_aes_arb.sv
// Bench for ccm_aes_arb: a hand-computed vector table, directed corner sequences
// and a randomized run scored against a queue-based model of owners in flight.
module tb_ccm_aes_arb;
  import ccm_pkg::*;

  localparam int WB = 128;
  localparam int MO = 4;
`ifdef CCM_ARB_FIXED_PRI_EN
  localparam bit FIXED_PRI = 1'b1;
`else
  localparam bit FIXED_PRI = 1'b0;
`endif
  localparam logic [127:0] KEY = 128'h2b7e1516_28aed2a6_abf71588_09cf4f3c;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  ccm_aes_arb_if #(.WIDTH_BLOCK(WB), .MAX_OUT(MO)) bus ();
  ccm_aes_arb #(.WIDTH_BLOCK(WB), .MAX_OUT(MO)) dut (.clk(clk), .reset(reset), .bus(bus));

  int n_pass = 0;
  int n_chk  = 0;

  // Reference model state: owners in flight (oldest first), tie pointer, sticky error.
  bit           tag_q[$];
  logic [127:0] eng_q[$];
  bit           lw;
  bit           m_err;
  logic [1:0]   last_rdy;
  logic [1:0]   dut_rdy;

  typedef struct {
    logic [1:0] vld;
    logic       oe;
    logic [1:0] rdy;
    logic [1:0] rsp;
    logic [2:0] cnt;
  } vec_t;
  vec_t tbl[10];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h want %h", name, act, exp);
  endtask

  function automatic logic [127:0] enc(input logic [127:0] d);
    return {d[63:0], d[127:64]} ^ KEY;
  endfunction

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic do_reset();
    bus.req_valid    = 2'b00;
    bus.req_data_0   = '0;
    bus.req_data_1   = '0;
    bus.aes_out_en   = 1'b0;
    bus.aes_out_data = '0;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    tag_q.delete();
    eng_q.delete();
    lw = 1'b1;
    m_err = 1'b0;
    last_rdy = 2'b00;
  endtask

  // One cycle: drive inputs, check combinational ready, advance, check registered outputs.
  task automatic drive_cycle(input logic [1:0] vld, input logic [127:0] d0, input logic [127:0] d1,
                             input logic oe, input logic [127:0] od);
    bit           id;
    bit           h;
    logic [1:0]   rdy;
    logic [1:0]   exp_rsp;
    logic [127:0] exp_rsp_d;
    logic [127:0] exp_in_d;
    bit           exp_in_en;
    bus.req_valid = vld; bus.req_data_0 = d0; bus.req_data_1 = d1;
    bus.aes_out_en = oe; bus.aes_out_data = od;
    #1;
    id = (vld == 2'b10);
    if (vld == 2'b11) id = FIXED_PRI ? 1'b0 : !lw;
    rdy = 2'b00;
    if (vld != 2'b00 && tag_q.size() < MO) rdy = id ? 2'b10 : 2'b01;
    dut_rdy = bus.req_ready;
    chk("req_ready", bus.req_ready, rdy);
    last_rdy = rdy;
    exp_rsp = 2'b00;
    exp_rsp_d = '0;
    if (oe) begin
      if (tag_q.size() == 0) m_err = 1'b1;
      else begin
        h = tag_q.pop_front();
        exp_rsp = h ? 2'b10 : 2'b01;
        exp_rsp_d = od;
      end
    end
    exp_in_en = (rdy != 2'b00);
    exp_in_d = id ? d1 : d0;
    if (exp_in_en) begin
      tag_q.push_back(id);
      lw = id;
    end
    @(posedge clk); #1;
    chk("aes_in_en", bus.aes_in_en, exp_in_en);
    if (exp_in_en) chk("aes_in_data", bus.aes_in_data, exp_in_d);
    chk("rsp_en", bus.rsp_en, exp_rsp);
    if (exp_rsp != 2'b00) chk("rsp_data", bus.rsp_data, exp_rsp_d);
    chk("out_cnt", bus.out_cnt, tag_q.size());
    chk("err_unexp", bus.err_unexp, m_err);
    if (bus.aes_in_en) eng_q.push_back(enc(bus.aes_in_data));
  endtask

  task automatic idle();
    drive_cycle(2'b00, '0, '0, 1'b0, '0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [127:0] d0, d1, od, res;
    logic [1:0]   vld;
    logic         oe;

    // Table: cumulative sequence from reset with the engine mostly stalled.
    tbl[0] = '{2'b00, 1'b0, 2'b00, 2'b00, 3'd0};
    tbl[1] = '{2'b11, 1'b0, 2'b01, 2'b00, 3'd1};
    tbl[2] = '{2'b11, 1'b0, FIXED_PRI ? 2'b01 : 2'b10, 2'b00, 3'd2};
    tbl[3] = '{2'b10, 1'b1, 2'b10, 2'b01, 3'd2};
    tbl[4] = '{2'b11, 1'b0, 2'b01, 2'b00, 3'd3};
    tbl[5] = '{2'b01, 1'b0, 2'b01, 2'b00, 3'd4};
    tbl[6] = '{2'b11, 1'b0, 2'b00, 2'b00, 3'd4};
    tbl[7] = '{2'b11, 1'b1, 2'b00, FIXED_PRI ? 2'b01 : 2'b10, 3'd3};
    tbl[8] = '{2'b11, 1'b0, FIXED_PRI ? 2'b01 : 2'b10, 2'b00, 3'd4};
    tbl[9] = '{2'b00, 1'b1, 2'b00, 2'b10, 3'd3};

    do_reset();
    // Reset state.
    chk("rst_req_ready", bus.req_ready, 2'b00);
    chk("rst_aes_in_en", bus.aes_in_en, 1'b0);
    chk("rst_aes_in_data", bus.aes_in_data, '0);
    chk("rst_rsp_en", bus.rsp_en, 2'b00);
    chk("rst_rsp_data", bus.rsp_data, '0);
    chk("rst_out_cnt", bus.out_cnt, 0);
    chk("rst_err_unexp", bus.err_unexp, 1'b0);

    for (int i = 0; i < 10; i++) begin
      d0 = {4{32'hA000_0000 + i}};
      d1 = {4{32'hB000_0000 + i}};
      od = {4{32'hC000_0000 + i}};
      bus.req_valid = tbl[i].vld; bus.req_data_0 = d0; bus.req_data_1 = d1;
      bus.aes_out_en = tbl[i].oe; bus.aes_out_data = od;
      #1;
      chk($sformatf("tbl%0d_ready", i), bus.req_ready, tbl[i].rdy);
      @(posedge clk); #1;
      chk($sformatf("tbl%0d_cnt", i), bus.out_cnt, tbl[i].cnt);
      chk($sformatf("tbl%0d_in_en", i), bus.aes_in_en, tbl[i].rdy != 2'b00);
      if (tbl[i].rdy != 2'b00)
        chk($sformatf("tbl%0d_in_data", i), bus.aes_in_data, tbl[i].rdy[1] ? d1 : d0);
      chk($sformatf("tbl%0d_rsp_en", i), bus.rsp_en, tbl[i].rsp);
      if (tbl[i].rsp != 2'b00) chk($sformatf("tbl%0d_rsp_data", i), bus.rsp_data, od);
    end

    // Single MAC request, engine latency 5.
    do_reset();
    drive_cycle(2'b01, 128'h000102030405060708090a0b0c0d0e0f, '0, 1'b0, '0);
    chk("single_cnt1", bus.out_cnt, 1);
    repeat (4) idle();
    res = eng_q.pop_front();
    drive_cycle(2'b00, '0, '0, 1'b1, res);
    chk("single_rsp_en", bus.rsp_en, 2'b01);
    chk("single_rsp_data", bus.rsp_data, enc(128'h000102030405060708090a0b0c0d0e0f));
    chk("single_cnt0", bus.out_cnt, 0);

    // Contention: both valid for six cycles, engine returning as it can.
    do_reset();
    for (int i = 0; i < 6; i++) begin
      oe = (eng_q.size() != 0);
      res = oe ? eng_q.pop_front() : '0;
      drive_cycle(2'b11, {4{32'h1111_0000 + i}}, {4{32'h2222_0000 + i}}, oe, res);
      chk($sformatf("contend%0d_grant", i), dut_rdy, (FIXED_PRI || i % 2 == 0) ? 2'b01 : 2'b10);
    end
    while (eng_q.size() != 0) begin
      res = eng_q.pop_front();
      drive_cycle(2'b00, '0, '0, 1'b1, res);
    end

    // Spurious result with nothing in flight: sticky error, no response.
    do_reset();
    drive_cycle(2'b00, '0, '0, 1'b1, 128'hdead);
    chk("spur_rsp_en", bus.rsp_en, 2'b00);
    repeat (3) idle();
    chk("spur_sticky", bus.err_unexp, 1'b1);

    // Reset mid-operation with three blocks in flight, then a stale result.
    do_reset();
    repeat (3) drive_cycle(2'b01, rnd128(), '0, 1'b0, '0);
    chk("mid_cnt3", bus.out_cnt, 3);
    bus.req_valid = 2'b00;
    reset = 1'b1;
    #1;
    chk("mid_rst_in_en", bus.aes_in_en, 1'b0);
    chk("mid_rst_in_data", bus.aes_in_data, '0);
    chk("mid_rst_rsp_en", bus.rsp_en, 2'b00);
    chk("mid_rst_cnt", bus.out_cnt, 0);
    chk("mid_rst_ready", bus.req_ready, 2'b00);
    do_reset();
    drive_cycle(2'b00, '0, '0, 1'b1, 128'h5a5a);
    chk("stale_err", bus.err_unexp, 1'b1);
    chk("stale_rsp_en", bus.rsp_en, 2'b00);

    // Randomized traffic against the model.
    do_reset();
    vld = 2'b00; d0 = '0; d1 = '0;
    for (int c = 0; c < 500; c++) begin
      for (int r = 0; r < 2; r++) begin
        if (!(vld[r] && !last_rdy[r])) begin
          vld[r] = ($urandom_range(0, 9) < 6);
          if (r == 0) d0 = rnd128(); else d1 = rnd128();
        end
      end
      oe = (eng_q.size() != 0) && ($urandom_range(0, 2) != 0);
      res = oe ? eng_q.pop_front() : '0;
      drive_cycle(vld, d0, d1, oe, res);
      if (last_rdy != 2'b00) vld = vld & ~last_rdy;
      last_rdy = 2'b00;
    end
    for (int c = 0; c < 20 && eng_q.size() != 0; c++) begin
      res = eng_q.pop_front();
      drive_cycle(2'b00, '0, '0, 1'b1, res);
    end
    chk("drain_cnt", bus.out_cnt, 0);
    chk("drain_err", bus.err_unexp, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
